cp0_ext: RTL and testbench

Parametrised coprocessor-0 for the pipelined MIPS core. It supersedes the fixed-width CP0 and owns Status, Cause, EPC, PRId, BadVAddr, Count and Compare. It arbitrates exceptions, a configurable number of external interrupt lines and an optional internal Count/Compare timer interrupt into a single `int_req` toward the pipeline flush logic. It sits beside the MEM/WB boundary and is written and read by `mtc0`/`mfc0`/`eret`.

---
 rtl/cp0_pkg.sv | 32 +++
 rtl/cp0_timer.sv | 27 ++
 rtl/cp0_ext.sv | 110 +++++++++++
 tb/tb_cp0_ext.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// cp0_pkg: shared CP0 register numbers, Status/Cause bit positions, op and exception codes.
package cp0_pkg;
    localparam int CP0_OP_LEN   = 2;
    localparam int EXC_CODE_LEN = 5;
    typedef enum logic [CP0_OP_LEN-1:0] {
        CP0_OP_NONE = 2'd0,
        CP0_OP_MTC0 = 2'd1,
        CP0_OP_ERET = 2'd2
    } cp0_op_e;
    localparam logic [EXC_CODE_LEN-1:0] EXC_CODE_INT  = 5'd0;
    localparam logic [EXC_CODE_LEN-1:0] EXC_CODE_ADEL = 5'd4;
    localparam logic [EXC_CODE_LEN-1:0] EXC_CODE_ADES = 5'd5;
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;
    localparam int ST_IE       = 0;
    localparam int ST_EXL      = 1;
    localparam int ST_IM       = 8;
    localparam int ST_IM_TIMER = 15;
    localparam int CA_EXC      = 2;
    localparam int CA_IP       = 8;
    localparam int CA_IP_TIMER = 15;
    localparam int CA_TI       = 30;
    localparam int CA_BD       = 31;
    function automatic logic [31:0] align4(input logic [31:0] a);
        return a & ~32'd3;
    endfunction
endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: free-running Count, Compare and the sticky TI flag raised when Count enters Compare.
module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] write_data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);
    logic [31:0] count_next;
    assign count_next = count_we ? write_data : count + 32'd1;
    // A Compare write acknowledges the timer, so it beats a match in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            count   <= count_next;
            if (compare_we)
                compare <= write_data;
            ti <= compare_we ? 1'b0 : ti | (count_next == compare);
        end
    end
endmodule

// File: rtl/cp0_ext.sv
// cp0_ext: parametrised CP0 (Status/Cause/EPC/PRId/BadVAddr) with exception/interrupt arbitration.
// Define CP0_TIMER_EN to add Count/Compare and the timer interrupt on IP[15].
module cp0_ext import cp0_pkg::*; #(
    parameter int          HW_INT_N = 6,
    parameter logic [31:0] PRID_VAL = 32'h0000_7a01
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4:0]              addr,
    input  logic [31:0]             write_data,
    input  logic [CP0_OP_LEN-1:0]   op,
    input  logic [EXC_CODE_LEN-1:0] exc,
    input  logic                    bd,
    input  logic [31:0]             epc_in,
    input  logic [31:0]             badvaddr_in,
    input  logic [HW_INT_N-1:0]     hw_int,
    output logic                    int_req,
    output logic [31:0]             epc_out,
    output logic [31:0]             read_data
);
    logic                    ie, exl, bd_r, mtc0, eret, int_hw, int_pend;
    logic [HW_INT_N-1:0]     im, ip;
    logic [EXC_CODE_LEN-1:0] exc_code, code_next;
    logic [31:0]             epc, badvaddr, timer_rd, status_w, cause_w;
    assign mtc0 = op == CP0_OP_MTC0;
    assign eret = op == CP0_OP_ERET;
`ifdef CP0_TIMER_EN
    logic        im_t, ti;
    logic [31:0] count, compare;
    cp0_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (mtc0 && addr == CP0_COUNT),
        .compare_we (mtc0 && addr == CP0_COMPARE),
        .write_data (write_data),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );
    always_ff @(posedge clk) begin
        if (reset)
            im_t <= 1'b0;
        else if (mtc0 && addr == CP0_STATUS)
            im_t <= write_data[ST_IM_TIMER];
    end
    assign int_pend = |({ti, hw_int} & {im_t, im});
    assign timer_rd = addr == CP0_COUNT ? count : addr == CP0_COMPARE ? compare : '0;
`else
    assign int_pend = |(hw_int & im);
    assign timer_rd = '0;
`endif
    // External lines feed int_req directly; Cause.IP only mirrors them a cycle later.
    assign int_hw    = !exl && ie && int_pend;
    assign int_req   = (exc != '0) || int_hw;
    assign code_next = int_hw ? EXC_CODE_INT : exc;
    assign epc_out   = (mtc0 && addr == CP0_EPC) ? align4(write_data) : epc;
    always_comb begin
        status_w                          = '0;
        status_w[ST_IE]                   = ie;
        status_w[ST_EXL]                  = exl;
        status_w[ST_IM+:HW_INT_N]         = im;
        cause_w                           = '0;
        cause_w[CA_EXC+:EXC_CODE_LEN]     = exc_code;
        cause_w[CA_IP+:HW_INT_N]          = ip;
        cause_w[CA_BD]                    = bd_r;
`ifdef CP0_TIMER_EN
        status_w[ST_IM_TIMER]             = im_t;
        cause_w[CA_IP_TIMER]              = ti;
        cause_w[CA_TI]                    = ti;
`endif
        read_data = addr == CP0_BADVADDR ? badvaddr :
                    addr == CP0_STATUS   ? status_w :
                    addr == CP0_CAUSE    ? cause_w  :
                    addr == CP0_EPC      ? epc      :
                    addr == CP0_PRID     ? PRID_VAL : timer_rd;
    end
    // mtc0 outranks eret, which outranks taking an exception or interrupt.
    always_ff @(posedge clk) begin
        if (reset) begin
            ie       <= 1'b0;
            exl      <= 1'b0;
            im       <= '0;
            ip       <= '0;
            exc_code <= '0;
            bd_r     <= 1'b0;
            epc      <= '0;
            badvaddr <= '0;
        end else begin
            ip <= hw_int;
            if (mtc0) begin
                if (addr == CP0_STATUS) begin
                    ie  <= write_data[ST_IE];
                    exl <= write_data[ST_EXL];
                    im  <= write_data[ST_IM+:HW_INT_N];
                end
                if (addr == CP0_EPC)
                    epc <= align4(write_data);
            end else if (eret) begin
                exl <= 1'b0;
            end else if (int_req) begin
                exl      <= 1'b1;
                bd_r     <= bd;
                exc_code <= code_next;
                epc      <= align4(epc_in) - (bd ? 32'd4 : 32'd0);
                if (code_next == EXC_CODE_ADEL || code_next == EXC_CODE_ADES)
                    badvaddr <= badvaddr_in;
            end
        end
    end
endmodule

// File: tb/tb_cp0_ext.sv
// tb_cp0_ext: directed and random checks of cp0_ext against a word-level register model.
module tb_cp0_ext;
    import cp0_pkg::*;
    localparam int          N    = 6;
    localparam logic [31:0] PRID = 32'h0000_7a01;
`ifdef CP0_TIMER_EN
    localparam bit TMR = 1'b1;
`else
    localparam bit TMR = 1'b0;
`endif
    localparam logic [31:0] ST_MASK = 32'h3 | (((32'd1 << N) - 32'd1) << 8) | (TMR ? 32'h8000 : 32'h0);

    logic        clk = 1'b0, reset = 1'b1, bd = 1'b0, int_req;
    logic [4:0]  addr = '0, exc = '0;
    logic [1:0]  op = '0;
    logic [31:0] write_data = '0, epc_in = '0, badvaddr_in = '0, epc_out, read_data;
    logic [N-1:0] hw_int = '0;
    int vectors = 0, errors = 0;

    logic [31:0] m_status = '0, m_epc = '0, m_bad = '0, m_count = '0, m_compare = '0;
    logic [4:0]  m_code = '0;
    logic        m_bd = 1'b0, m_ti = 1'b0;
    logic [7:0]  m_ip = '0;

    int r, r2;
    logic [1:0]  r_op;
    logic [4:0]  r_addr, r_exc;
    logic [31:0] r_wd;
    logic [4:0]  addr_pool [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};

    cp0_ext #(.HW_INT_N(N), .PRID_VAL(PRID)) dut (
        .clk(clk), .reset(reset), .addr(addr), .write_data(write_data), .op(op),
        .exc(exc), .bd(bd), .epc_in(epc_in), .badvaddr_in(badvaddr_in), .hw_int(hw_int),
        .int_req(int_req), .epc_out(epc_out), .read_data(read_data)
    );

    always #5 clk = ~clk;

    function automatic bit m_int_hw();
        logic [31:0] p;
        p = ((32'(m_ti) << 15) | (32'(hw_int) << 8)) & m_status & 32'h0000_FF00;
        return !m_status[1] && m_status[0] && p != 32'd0;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_bad;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ti) << 15) |
                            (32'(m_ip) << 8) | (32'(m_code) << 2);
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_status = '0; m_epc = '0; m_bad = '0; m_count = '0; m_compare = '0;
        m_code = '0; m_bd = 1'b0; m_ti = 1'b0; m_ip = '0;
    endtask

    task automatic model_clock();
        bit          ihw, ireq;
        logic [31:0] ncount;
        logic [4:0]  code;
        if (reset) begin
            model_reset();
            return;
        end
        ihw  = m_int_hw();
        ireq = ihw || exc != 5'd0;
        if (TMR) begin
            ncount = (op == CP0_OP_MTC0 && addr == 5'd9) ? write_data : m_count + 32'd1;
            if (op == CP0_OP_MTC0 && addr == 5'd11) begin
                m_ti      = 1'b0;
                m_compare = write_data;
            end else if (ncount == m_compare) begin
                m_ti = 1'b1;
            end
            m_count = ncount;
        end
        m_ip = 8'(hw_int);
        if (op == CP0_OP_MTC0) begin
            if (addr == 5'd12) m_status = write_data & ST_MASK;
            if (addr == 5'd14) m_epc = write_data & ~32'd3;
        end else if (op == CP0_OP_ERET) begin
            m_status[1] = 1'b0;
        end else if (ireq) begin
            code        = ihw ? 5'd0 : exc;
            m_status[1] = 1'b1;
            m_bd        = bd;
            m_code      = code;
            m_epc       = (epc_in & ~32'd3) - (bd ? 32'd4 : 32'd0);
            if (code == 5'd4 || code == 5'd5) m_bad = badvaddr_in;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] o, input logic [4:0] a, input logic [31:0] wd = 0,
                         input logic [4:0] e = 0, input logic b = 0, input logic [31:0] pc = 0,
                         input logic [31:0] bv = 0, input logic [N-1:0] h = 0);
        op = o; addr = a; write_data = wd; exc = e; bd = b; epc_in = pc; badvaddr_in = bv; hw_int = h;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        chk("int_req", 32'(int_req), 32'(m_int_hw() || exc != 5'd0));
        chk("epc_out", epc_out, (op == CP0_OP_MTC0 && addr == 5'd14) ? (write_data & ~32'd3) : m_epc);
        chk("read_data", read_data, m_read(addr));
        @(posedge clk);
        model_clock();
        #1;
    endtask

    initial begin
        drive(CP0_OP_NONE, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        drive(CP0_OP_NONE, 5'd15, 0, EXC_CODE_ADEL);
        chk("reset_int_req_exc", 32'(int_req), 32'd1);
        tick();
        reset = 1'b0;
        drive(CP0_OP_NONE, 5'd15); chk("prid", read_data, PRID); chk("reset_int_req", 32'(int_req), 32'd0); tick();
        drive(CP0_OP_NONE, 5'd12); chk("reset_status", read_data, 32'd0); tick();
        drive(CP0_OP_NONE, 5'd13); chk("reset_cause", read_data, 32'd0); tick();
        drive(CP0_OP_NONE, 5'd14); chk("reset_epc", read_data, 32'd0); tick();
        // Unmasked external line
        drive(CP0_OP_MTC0, 5'd12, 32'h0000_0401); tick();
        drive(CP0_OP_NONE, 5'd13, 0, 0, 0, 32'h2003, 0, 6'b000100);
        chk("hw_int_req", 32'(int_req), 32'd1); tick();
        drive(CP0_OP_NONE, 5'd13); chk("hw_cause", read_data, 32'h0000_0400); tick();
        drive(CP0_OP_NONE, 5'd12); chk("hw_status_exl", read_data, 32'h0000_0403); tick();
        drive(CP0_OP_NONE, 5'd14); chk("hw_epc", read_data, 32'h0000_2000); tick();
        drive(CP0_OP_ERET, 5'd12); tick();
        drive(CP0_OP_NONE, 5'd12); chk("eret_status", read_data, 32'h0000_0401); tick();
        // AdEL in a delay slot
        drive(CP0_OP_NONE, 5'd14, 0, EXC_CODE_ADEL, 1'b1, 32'h3008, 32'h1235);
        chk("adel_int_req", 32'(int_req), 32'd1); tick();
        drive(CP0_OP_NONE, 5'd14); chk("adel_epc", read_data, 32'h0000_3004); tick();
        drive(CP0_OP_NONE, 5'd13); chk("adel_cause", read_data, 32'h8000_0010); tick();
        drive(CP0_OP_NONE, 5'd8);  chk("adel_badvaddr", read_data, 32'h0000_1235); tick();
        // EPC write bypass; EXL untouched
        drive(CP0_OP_MTC0, 5'd14, 32'h3007); chk("epc_bypass", epc_out, 32'h0000_3004); tick();
        drive(CP0_OP_NONE, 5'd12); chk("mtc0_keeps_exl", read_data, 32'h0000_0403); tick();
        drive(CP0_OP_NONE, 5'd14); chk("epc_written", read_data, 32'h0000_3004); tick();
        // Interrupt beats a simultaneous AdES
        drive(CP0_OP_ERET, 5'd0); tick();
        drive(CP0_OP_NONE, 5'd0, 0, EXC_CODE_ADES, 1'b0, 32'h4000, 32'h9999, 6'b000100); tick();
        drive(CP0_OP_NONE, 5'd13); chk("int_wins_cause", read_data, 32'h0000_0400); tick();
        drive(CP0_OP_NONE, 5'd8);  chk("int_wins_badvaddr", read_data, 32'h0000_1235); tick();
        // Reset overrides a write in the same cycle
        reset = 1'b1;
        drive(CP0_OP_MTC0, 5'd14, 32'hABC0, 0, 0, 0, 0, '1); tick();
        reset = 1'b0;
        drive(CP0_OP_NONE, 5'd14); chk("reset_mid_epc", epc_out, 32'd0); tick();
        drive(CP0_OP_NONE, 5'd13); chk("reset_mid_cause", read_data, 32'd0); tick();
`ifdef CP0_TIMER_EN
        drive(CP0_OP_MTC0, 5'd12, 32'h0000_8001); tick();
        drive(CP0_OP_MTC0, 5'd11, 32'd13); tick();
        drive(CP0_OP_MTC0, 5'd9, 32'd10); tick();
        drive(CP0_OP_NONE, 5'd9); chk("count_load", read_data, 32'd10); tick();
        drive(CP0_OP_NONE, 5'd9); tick();
        drive(CP0_OP_NONE, 5'd13); chk("timer_no_req_yet", 32'(int_req), 32'd0); tick();
        drive(CP0_OP_NONE, 5'd13);
        chk("timer_req", 32'(int_req), 32'd1);
        chk("timer_ti", read_data & 32'h4000_8000, 32'h4000_8000); tick();
        drive(CP0_OP_MTC0, 5'd11, 32'd100); tick();
        drive(CP0_OP_NONE, 5'd13); chk("ti_cleared", read_data & 32'h4000_8000, 32'd0); tick();
        drive(CP0_OP_ERET, 5'd0); tick();
        drive(CP0_OP_MTC0, 5'd11, 32'd0); tick();
        drive(CP0_OP_MTC0, 5'd9, 32'hFFFF_FFFE); tick();
        drive(CP0_OP_NONE, 5'd9); chk("wrap_ff_req", 32'(int_req), 32'd0); tick();
        drive(CP0_OP_NONE, 5'd9); chk("wrap_count", read_data, 32'hFFFF_FFFF); tick();
        drive(CP0_OP_NONE, 5'd13);
        chk("wrap_req", 32'(int_req), 32'd1);
        chk("wrap_ti", read_data & 32'h4000_8000, 32'h4000_8000); tick();
`else
        drive(CP0_OP_MTC0, 5'd9, 32'h55); tick();
        drive(CP0_OP_NONE, 5'd9); chk("no_timer_count", read_data, 32'd0); tick();
        drive(CP0_OP_MTC0, 5'd11, 32'h66); tick();
        drive(CP0_OP_NONE, 5'd11); chk("no_timer_compare", read_data, 32'd0); tick();
`endif
        for (int i = 0; i < 400; i++) begin
            r      = $urandom_range(0, 99);
            r_op   = r < 15 ? CP0_OP_MTC0 : r < 22 ? CP0_OP_ERET : CP0_OP_NONE;
            r_addr = addr_pool[$urandom_range(0, 7)];
            r_wd   = $urandom;
            if (r_addr == 5'd9 && $urandom_range(0, 1) == 1)
                r_wd = m_compare - 32'($urandom_range(1, 4));
            r2    = $urandom_range(0, 9);
            r_exc = r2 < 7 ? 5'd0 : r2 == 7 ? EXC_CODE_ADEL : r2 == 8 ? EXC_CODE_ADES : 5'($urandom_range(1, 31));
            reset = $urandom_range(0, 99) == 0;
            drive(r_op, r_addr, r_wd, r_exc, 1'($urandom), $urandom, $urandom, N'($urandom & $urandom));
            tick();
        end
        reset = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
